// File: rtl/qnr_qtable_sequencer.sv
// rtl/qnr_qtable_sequencer.sv - quantizer coefficient sequencer and Q-table access controller
module qnr_qtable_sequencer #(
  parameter int DW = 12,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode_420,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sof,
  output logic          qt_ren,
  output logic [6:0]    qt_raddr,
  input  logic [TW-1:0] qt_rdata,
  output logic          qt_we,
  output logic [6:0]    qt_waddr,
  output logic [TW-1:0] qt_wdata,
  input  logic          host_wr_valid,
  output logic          host_wr_ready,
  input  logic [6:0]    host_wr_addr,
  input  logic [TW-1:0] host_wr_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_coef,
  output logic [TW-1:0] out_q,
  output logic [5:0]    out_qidx,
  output logic          out_tsel,
  output logic          out_last,
  output logic          busy,
  output logic          err_sof
);

  // IDLE/RUN is fully implied by the coefficient counter; the enum names it.
  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic [5:0] qnt_cnt, cnt_next;
  logic [2:0] comp, comp_next;
  logic       mode, mode_next;
  logic       err_next;

  // Values the current input beat will use; an sof beat restarts at index 0, comp 0.
  logic [5:0] beat_idx;
  logic [2:0] beat_comp;
  logic       beat_mode;
  logic       beat_tsel;
  logic       stage_free;
  logic       accept;

  // Sequencer state register: counter, component, latched sampling mode, sof error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      qnt_cnt <= 6'd0;
      comp    <= 3'd0;
      mode    <= 1'b0;
      err_sof <= 1'b0;
    end else begin
      qnt_cnt <= cnt_next;
      comp    <= comp_next;
      mode    <= mode_next;
      err_sof <= err_next;
    end
  end

  // Handshake, host arbitration, table read address and next sequencer state.
  always_comb begin
    state         = (qnt_cnt == 6'd0) ? IDLE : RUN;
    stage_free    = ~out_valid | out_ready;
    // Host writes win in IDLE so tables only change between blocks.
    in_ready      = stage_free & ~((state == IDLE) & host_wr_valid);
    accept        = in_valid & in_ready;
    host_wr_ready = (state == IDLE);
    qt_we         = host_wr_valid & host_wr_ready;

    beat_idx  = in_sof ? 6'd0 : qnt_cnt;
    beat_comp = in_sof ? 3'd0 : comp;
    beat_mode = in_sof ? mode_420 : mode;
    beat_tsel = beat_mode ? (beat_comp >= 3'd4) : (beat_comp >= 3'd1);

    qt_ren   = accept;
    qt_raddr = {beat_tsel, beat_idx};

    cnt_next  = qnt_cnt;
    comp_next = comp;
    mode_next = mode;
    err_next  = 1'b0;
    if (accept) begin
      cnt_next  = beat_idx + 6'd1;
      comp_next = beat_comp;
      mode_next = beat_mode;
      err_next  = in_sof & (state == RUN);
      if (beat_idx == 6'd63) begin
        comp_next = (beat_comp == (beat_mode ? 3'd5 : 3'd2)) ? 3'd0 : beat_comp + 3'd1;
      end
    end
  end

  // Output stage: capture the beat alongside its table read; hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_qidx  <= 6'd0;
      out_tsel  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_coef  <= in_data;
      out_qidx  <= beat_idx;
      out_tsel  <= beat_tsel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // The table holds its read data while qt_ren is low, so out_q stays stable in a stall.
  assign out_q    = qt_rdata;
  assign out_last = (out_qidx == 6'd63);
  assign busy     = (state == RUN);
  assign qt_waddr = host_wr_addr;
  assign qt_wdata = host_wr_data;

endmodule

// File: tb/tb_qnr_qtable_sequencer.sv
// tb/tb_qnr_qtable_sequencer.sv - directed bench for the quantizer Q-table sequencer
module tb_qnr_qtable_sequencer;
  localparam int DW = 12;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst, mode_420, in_valid, in_sof, out_ready, host_wr_valid;
  logic [DW-1:0] in_data;
  logic [6:0]    host_wr_addr;
  logic [TW-1:0] host_wr_data;
  logic          in_ready, qt_ren, qt_we, host_wr_ready, out_valid, out_tsel, out_last, busy, err_sof;
  logic [6:0]    qt_raddr, qt_waddr;
  logic [TW-1:0] qt_rdata, qt_wdata, out_q;
  logic [DW-1:0] out_coef;
  logic [5:0]    out_qidx;

  always #5 clk = ~clk;

  qnr_qtable_sequencer #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .mode_420(mode_420),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .qt_ren(qt_ren), .qt_raddr(qt_raddr), .qt_rdata(qt_rdata),
    .qt_we(qt_we), .qt_waddr(qt_waddr), .qt_wdata(qt_wdata),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef), .out_q(out_q),
    .out_qidx(out_qidx), .out_tsel(out_tsel), .out_last(out_last),
    .busy(busy), .err_sof(err_sof)
  );

  // Q-table RAM with 1-cycle read latency; gold is the bench's own view of its contents.
  logic [TW-1:0] qmem [128];
  logic [TW-1:0] gold [128];
  always @(posedge clk) begin
    if (qt_we) qmem[qt_waddr] <= qt_wdata;
    if (qt_ren) qt_rdata <= qmem[qt_raddr];
  end

  typedef struct packed {
    logic [DW-1:0] coef;
    logic [5:0]    idx;
    logic          tsel;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         e;
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] coef_seq = '0;
  logic [DW-1:0] held_coef;
  logic [TW-1:0] held_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every emitted operand is compared with the next expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_coef", out_coef, e.coef);
        check("out_qidx", out_qidx, e.idx);
        check("out_tsel", out_tsel, e.tsel);
        check("out_q", out_q, gold[{e.tsel, e.idx}]);
        check("out_last", out_last, e.idx == 6'd63);
      end
    end
  end

  // Offer one beat (bounded wait), check the read request, return one cycle after acceptance.
  task automatic send(input logic sof, input int eidx, input logic etsel);
    int    n;
    beat_t b;
    n = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = coef_seq;
    #1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
    end else begin
      check("qt_ren", qt_ren, 1);
      check("qt_raddr", qt_raddr, {etsel, eidx[5:0]});
      b.coef = coef_seq;
      b.idx  = eidx[5:0];
      b.tsel = etsel;
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    coef_seq = coef_seq + 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      qmem[i] = 8'((i * 5) + 3);
      gold[i] = 8'((i * 5) + 3);
    end
    qt_rdata = '0;
    rst = 1'b1; mode_420 = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    out_ready = 1'b1; host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err_sof", err_sof, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_host_wr_ready", host_wr_ready, 1);
    check("rst_qt_ren", qt_ren, 0);
    check("rst_qt_we", qt_we, 0);
    @(posedge clk); #1;

    // 4:4:4 frame: Y, Cb, Cr -> tsel 0,1,1.
    mode_420 = 1'b0;
    for (int i = 0; i < 192; i++) send(i == 0, i % 64, (i / 64) >= 1);
    check("444_busy_end", busy, 0);

    // 4:2:0 frame of 6 blocks plus one block that wraps back to luma.
    mode_420 = 1'b1;
    for (int i = 0; i < 448; i++) send(i == 0, i % 64, ((i / 64) % 6) >= 4);
    mode_420 = 1'b0;

    // Stall 1-0-0-1 in the middle of a luma block.
    for (int i = 0; i < 10; i++) send(i == 0, i, 1'b0);
    check("mid_busy", busy, 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = coef_seq;
    #1;
    check("stall_in_ready", in_ready, 0);
    check("stall_qt_ren", qt_ren, 0);
    check("stall_qidx0", out_qidx, 9);
    held_coef = out_coef;
    held_q    = out_q;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_qidx", out_qidx, 9);
      check("stall_coef", out_coef, held_coef);
      check("stall_q", out_q, held_q);
      check("stall_ren", qt_ren, 0);
    end
    out_ready = 1'b1;
    for (int i = 10; i < 64; i++) send(1'b0, i, 1'b0);

    // Host write requested mid-block waits for the block boundary.
    for (int i = 0; i < 10; i++) send(i == 0, i, 1'b0);
    host_wr_valid = 1'b1;
    host_wr_addr  = 7'h05;
    host_wr_data  = 8'h3C;
    #1;
    check("hw_ready_run", host_wr_ready, 0);
    check("hw_we_run", qt_we, 0);
    for (int i = 10; i < 63; i++) send(1'b0, i, 1'b0);
    check("hw_ready_62", host_wr_ready, 0);
    send(1'b0, 63, 1'b0);
    check("hw_ready_idle", host_wr_ready, 1);
    check("hw_we", qt_we, 1);
    check("hw_waddr", qt_waddr, 7'h05);
    check("hw_wdata", qt_wdata, 8'h3C);
    check("hw_in_ready", in_ready, 0);
    check("hw_no_ren", qt_ren, 0);
    @(posedge clk); #1;
    gold[5] = 8'h3C;
    host_wr_valid = 1'b0;
    #1;
    check("hw_we_off", qt_we, 0);
    check("hw_in_ready_back", in_ready, 1);
    for (int i = 0; i < 64; i++) begin
      send(i == 0, i, 1'b0);
      if (i == 5) check("hw_new_q", out_q, 8'h3C);
    end

    // sof at index 20 of a chroma block restarts at index 0, comp 0.
    for (int i = 0; i < 64; i++) send(i == 0, i, 1'b0);
    for (int i = 0; i < 20; i++) send(1'b0, i, 1'b1);
    check("sof_no_err_yet", err_sof, 0);
    send(1'b1, 0, 1'b0);
    check("sof_err_pulse", err_sof, 1);
    check("sof_qidx", out_qidx, 0);
    check("sof_tsel", out_tsel, 0);
    @(posedge clk); #1;
    check("sof_err_clear", err_sof, 0);
    for (int i = 1; i < 64; i++) send(1'b0, i, 1'b0);

    // Reset at index 30 drops the in-flight beat; next beat is index 0.
    mode_420 = 1'b1;
    for (int i = 0; i < 30; i++) send(i == 0, i, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    rst = 1'b0;
    mode_420 = 1'b0;
    send(1'b0, 0, 1'b0);
    check("rst_next_qidx", out_qidx, 0);
    check("rst_next_busy", busy, 1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
